serializer_sched: RTL and testbench
===================================

# serializer_sched

Symbol-rate scheduler for the DVI output serializers. It owns the 10-bit symbol phase and issues the shared `load_o` strobe to every lane serializer. It buffers per-symbol lane words from the TMDS encoders through a 2-entry valid/ready FIFO and presents one stable word per lane each symbol period. It also inserts fill words during link startup and on underflow, and provides the constant TMDS clock-lane pattern.

## Interface
- `DATA_W`, 10, symbol width; also the serializer ratio (one load per DATA_W cycles). Range 2..16.
- `LANES`, 3, number of data lanes.
- `STARTUP_SYMBOLS`, 16, fill-word symbols emitted after reset before data is accepted. Range 1..255.
- `FILL_WORD`, 10'b1101010100, word driven on every lane during startup and underflow.
- `CLK_PATTERN`, 10'b1111100000, clock-lane word.
- `clk_i`  in  1  serial bit clock; the only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `data_i`  in  LANES*DATA_W  next symbol for all lanes; lane k occupies bits [k*DATA_W +: DATA_W].
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  the scheduler accepts `data_i` this cycle.
- `load_o`  out  1  serializer load strobe, one cycle per symbol.
- `lane_o`  out  LANES*DATA_W  words to the serializers; stable for the whole symbol period.
- `clk_word_o`  out  DATA_W  always equal to CLK_PATTERN.
- `phase_o`  out  4  current bit phase, 0..DATA_W-1.
- `running_o`  out  1  high in RUN state.
- `underflow_o`  out  1  one-cycle pulse when a fill word is substituted in RUN.
- `underflow_cnt_o`  out  16  saturating underflow count.

## Operation
- Phase counter:
  - Counts 0..DATA_W-1 and wraps to 0.
  - `load_o` = (phase == DATA_W-1), decoded combinationally from the registered phase.
- Symbol boundary is the clock edge that ends a `load_o` cycle. At that edge:
  - Serializers capture the current `lane_o`.
  - The scheduler registers the next `lane_o` value.
- FSM states are STARTUP and RUN.
  - STARTUP:
    - `ready_o`=0 and the FIFO stays empty.
    - `lane_o` is FILL_WORD on all lanes at each boundary.
    - An 8-bit symbol counter increments at each boundary.
    - At the boundary where the counter reaches STARTUP_SYMBOLS, go to RUN.
  - RUN: stays in RUN until reset; there are no other transitions.
- FIFO:
  - 2 entries of LANES*DATA_W bits.
  - `ready_o` = RUN and FIFO not full.
  - A push occurs on a clock edge where `valid_i && ready_o`.
- Boundary action in RUN:
  - FIFO non-empty: pop the head into `lane_o`.
  - FIFO empty: `lane_o` <= FILL_WORD on all lanes, `underflow_o` pulses, and `underflow_cnt_o` increments, saturating at 16'hFFFF.
- Simultaneous push and pop at the same edge:
  - Occupancy is unchanged.
  - If the FIFO was empty, the pop sees empty, so an underflow occurs and the pushed word is stored. There is no bypass.
- Order is strictly FIFO; words are never dropped or duplicated.
- Reset (asynchronous, any time, including mid-symbol) sets:
  - phase=0, so `load_o`=0;
  - state=STARTUP, symbol counter=0;
  - FIFO empty, with buffered words discarded;
  - `lane_o`=FILL_WORD on all lanes;
  - `ready_o`=0, `running_o`=0, `underflow_o`=0, `underflow_cnt_o`=0.
- Release: the first `load_o` is in the DATA_W-th cycle after `rst_i` deasserts (cycle 9 for DATA_W=10, counting from 0).

## Timing
- `load_o` period is exactly DATA_W cycles and is high for 1 cycle.
- `lane_o`, `running_o` and `underflow_o` are registered and change only at boundary edges.
- `ready_o` is combinational from registered state only; it has no path from `valid_i`.
- Latency:
  - A word accepted with the FIFO empty appears on `lane_o` at the next boundary.
  - It is captured by the serializers one symbol period later.
- `running_o` rises at the STARTUP_SYMBOLS-th boundary. `ready_o` can be high from the following cycle onward.
- The first real data word on `lane_o` appears no earlier than boundary STARTUP_SYMBOLS+1.
- `clk_word_o` is constant, including during reset.

## Test plan
- **Reset/phase:** release reset -> `load_o` high on cycles 9, 19, 29…; `phase_o` counts 0..9; `lane_o`=3×10'b1101010100; `ready_o`=0.
- **Startup:** run 16 symbols -> `running_o` rises at the 16th boundary (cycle-9 edge of symbol 16); `ready_o` stays 0 before it and `underflow_cnt_o` stays 0.
- **Streaming:** push 0x3FF/0x001/0x155 (lanes 2/1/0), then a second word, as each symbol's `ready_o` allows -> words appear on `lane_o` in order, one per boundary, with no underflow pulses.
- **Full:** push 3 words back-to-back within one symbol -> `ready_o` drops after 2 accepts; the third word is held until the boundary pop, then accepted; all 3 appear in order.
- **Underflow:** stop `valid_i` in RUN -> at the next boundary `lane_o`=FILL_WORD, `underflow_o` pulses for 1 cycle and the count goes 0→1. A push coinciding with the empty-FIFO boundary still underflows, and that word appears at the following boundary.
- **Reset mid-stream:** assert `rst_i` at phase 4 with 2 words buffered -> all outputs return to reset values immediately; after release, the 16-symbol startup repeats and the buffered words never appear.

Source files
------------

// File: rtl/serializer_sched.sv
// Symbol-rate scheduler for the DVI serializers: owns the bit phase,
// issues load strobes and feeds lane words through a 2-entry FIFO.
module serializer_sched #(
  parameter int                DATA_W          = 10,
  parameter int                LANES           = 3,
  parameter int                STARTUP_SYMBOLS = 16,
  parameter logic [DATA_W-1:0] FILL_WORD       = 10'b1101010100,
  parameter logic [DATA_W-1:0] CLK_PATTERN     = 10'b1111100000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [LANES*DATA_W-1:0]   data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      load_o,
  output logic [LANES*DATA_W-1:0]   lane_o,
  output logic [DATA_W-1:0]         clk_word_o,
  output logic [3:0]                phase_o,
  output logic                      running_o,
  output logic                      underflow_o,
  output logic [15:0]               underflow_cnt_o
);

  localparam int          W    = LANES * DATA_W;
  localparam logic [3:0]  LAST = 4'(DATA_W - 1);
  localparam logic [7:0]  SYMS = 8'(STARTUP_SYMBOLS - 1);

  typedef enum logic {STARTUP, RUN} state_t;

  state_t         state_q, state_d;
  logic [3:0]     phase_q;
  logic [7:0]     sym_q, sym_d;
  logic [W-1:0]   mem_q [2];
  logic           wr_q, rd_q;
  logic [1:0]     cnt_q;
  logic [W-1:0]   lane_q;
  logic           uf_q;
  logic [15:0]    ufc_q;
  logic [W-1:0]   fill_all;
  logic           run, boundary, push, pop;

  assign fill_all = {LANES{FILL_WORD}};
  assign run      = (state_q == RUN);
  assign boundary = (phase_q == LAST);
  assign ready_o  = run && (cnt_q != 2'd2);
  assign push     = valid_i && ready_o;
  // Pop decision uses pre-edge occupancy: no bypass of a same-edge push.
  assign pop      = run && boundary && (cnt_q != 2'd0);

  assign load_o          = boundary;
  assign lane_o          = lane_q;
  assign clk_word_o      = CLK_PATTERN;
  assign phase_o         = phase_q;
  assign running_o       = run;
  assign underflow_o     = uf_q;
  assign underflow_cnt_o = ufc_q;

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    unique case (state_q)
      STARTUP: begin
        if (boundary) begin
          sym_d = sym_q + 8'd1;
          if (sym_q == SYMS) state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = STARTUP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= STARTUP;
      phase_q <= '0;
      sym_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      lane_q  <= fill_all;
      uf_q    <= 1'b0;
      ufc_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      phase_q <= boundary ? 4'd0 : phase_q + 4'd1;
      if (push) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
      cnt_q   <= cnt_q + {1'b0, push} - {1'b0, pop};
      uf_q    <= 1'b0;
      if (boundary) begin
        if (pop) begin
          lane_q <= mem_q[rd_q];
        end else begin
          lane_q <= fill_all;
          if (run) begin
            uf_q <= 1'b1;
            if (ufc_q != 16'hFFFF) ufc_q <= ufc_q + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serializer_sched.sv
// Scoreboard bench for serializer_sched: directed pushes feed a queue,
// a monitor checks lane_o after every boundary while running.
module tb_serializer_sched;

  localparam logic [9:0]  FILL  = 10'b1101010100;
  localparam logic [9:0]  CLKP  = 10'b1111100000;
  localparam logic [29:0] FILL3 = {FILL, FILL, FILL};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [29:0] data = '0;
  logic        ready, load, running, uf;
  logic [29:0] lane;
  logic [9:0]  clk_word;
  logic [3:0]  phase;
  logic [15:0] ufc;

  int tests = 0;
  int fails = 0;
  logic [29:0] sb [$];

  serializer_sched dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .data_i          (data),
    .valid_i         (valid),
    .ready_o         (ready),
    .load_o          (load),
    .lane_o          (lane),
    .clk_word_o      (clk_word),
    .phase_o         (phase),
    .running_o       (running),
    .underflow_o     (uf),
    .underflow_cnt_o (ufc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [29:0] w);
    int n = 0;
    valid = 1'b1;
    data  = w;
    while (!ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (ready) begin
      sb.push_back(w);
    end else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: word %0h not accepted", w);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_phase(input logic [3:0] p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phase != p && n < 40);
    if (phase != p) begin
      tests++;
      fails++;
      $display("FAIL wait_phase: got %0d expected %0d", phase, p);
    end
  endtask

  // Entered at the release negedge; leaves at cycle 160 (first RUN cycle).
  task automatic startup(input bit detail);
    int bad = 0;
    for (int c = 0; c < 160; c++) begin
      if (detail && c < 20) begin
        chk("phase", 32'(phase), 32'(c % 10));
        chk("load", 32'(load), 32'(c % 10 == 9));
      end
      if (ready || running || ufc != 0 || lane != FILL3) bad++;
      @(negedge clk);
    end
    chk("startup_quiet", 32'(bad), 32'd0);
    chk("running_rise", 32'(running), 32'd1);
    chk("ready_in_run", 32'(ready), 32'd1);
  endtask

  // Monitor: checks lane_o after each boundary that began in RUN.
  initial begin
    bit al = 0;
    bit ral = 0;
    logic [29:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        al = 0;
        ral = 0;
      end else begin
        if (al && ral) begin
          if (uf) begin
            chk("lane_fill", 32'(lane), 32'(FILL3));
          end else if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL lane_unexpected: got %0h expected fill", lane);
          end else begin
            e = sb.pop_front();
            chk("lane_data", 32'(lane), 32'(e));
          end
        end
        al = load;
        if (load) ral = running;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_lane", 32'(lane), 32'(FILL3));
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_flags", 32'({running, uf}), 32'd0);
    chk("rst_ufc", 32'(ufc), 32'd0);
    chk("rst_clkword", 32'(clk_word), 32'(CLKP));
    rst = 1'b0;
    startup(1'b1);

    send({10'h3FF, 10'h001, 10'h155});
    send({10'h0AA, 10'h2CC, 10'h133});
    wait_phase(4'd0);
    wait_phase(4'd0);
    chk("stream_no_uf", 32'(ufc), 32'd0);

    send({10'h111, 10'h222, 10'h333});
    send({10'h044, 10'h055, 10'h066});
    chk("full_ready_low", 32'(ready), 32'd0);
    send({10'h3A5, 10'h15A, 10'h0F0});
    chk("full_accept_phase", 32'(phase), 32'd1);

    wait_phase(4'd0);
    chk("drain_ufc_a", 32'(ufc), 32'd0);
    wait_phase(4'd0);
    chk("drain_ufc_b", 32'(ufc), 32'd0);
    wait_phase(4'd0);
    chk("uf_pulse", 32'(uf), 32'd1);
    chk("uf_count1", 32'(ufc), 32'd1);
    @(negedge clk);
    chk("uf_pulse_end", 32'(uf), 32'd0);

    wait_phase(4'd9);
    send({10'h2D2, 10'h1E1, 10'h0C3});
    chk("coinc_uf", 32'(uf), 32'd1);
    chk("coinc_count2", 32'(ufc), 32'd2);
    chk("coinc_lane_fill", 32'(lane), 32'(FILL3));
    wait_phase(4'd0);
    chk("coinc_no_uf", 32'(uf), 32'd0);
    chk("coinc_lane_word", 32'(lane), 32'({10'h2D2, 10'h1E1, 10'h0C3}));
    chk("coinc_count_hold", 32'(ufc), 32'd2);

    send({10'h3C3, 10'h3C3, 10'h3C3});
    send({10'h0FF, 10'h0FF, 10'h0FF});
    wait_phase(4'd4);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_lane", 32'(lane), 32'(FILL3));
    chk("mid_rst_phase", 32'(phase), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_flags", 32'({running, uf, load}), 32'd0);
    chk("mid_rst_ufc", 32'(ufc), 32'd0);
    chk("mid_rst_clkword", 32'(clk_word), 32'(CLKP));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    startup(1'b0);

    send({10'h001, 10'h002, 10'h004});
    wait_phase(4'd0);
    chk("restart_ufc", 32'(ufc), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
